// File: rtl/pspin_ingress_pkg.sv
// Shared types and constants for the PsPIN ingress slot writer.
// Latency: n/a (package only).
// Backpressure: n/a.
package pspin_ingress_pkg;

  // Slot writer FSM: wait for a free slot, stream one packet into it, then publish its descriptor.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_DRAIN = 2'd2
  } ingress_state_e;

  // Default descriptor field widths.
  localparam int unsigned DESC_ADDR_WIDTH = 32;
  localparam int unsigned DESC_LEN_WIDTH  = 16;

  // Number of stream beats that fit in one slot.
  function automatic int unsigned slot_beats(input int unsigned slot_bytes,
                                             input int unsigned keep_width);
    return slot_bytes / keep_width;
  endfunction

  localparam int unsigned SLOT_BEATS = slot_beats(2048, 64);

endpackage

// File: rtl/pspin_slot_ring.sv
// Slot ring bookkeeping: head (next slot to fill), tail (oldest occupied), occupancy and free-underflow flag.
// Latency: pointer and count updates visible the cycle after alloc/free.
// Backpressure: none; the caller must alloc only when !full. A free with no slots in use is dropped and flagged.
//
// Ports: clk, rstn (sync active-low); alloc/free strobes; head, slots_used, full, free_err status.
module pspin_slot_ring
  import pspin_ingress_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 16,
  localparam int unsigned PTR_W    = $clog2(NUM_SLOTS),
  localparam int unsigned CNT_W    = $clog2(NUM_SLOTS) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             alloc,
  input  logic             free,
  output logic [PTR_W-1:0] head,
  output logic [CNT_W-1:0] slots_used,
  output logic             full,
  output logic             free_err
);

  logic [PTR_W-1:0] tail;
  logic             free_ok;

  assign free_ok = free && (slots_used != '0);
  assign full    = (slots_used == CNT_W'(NUM_SLOTS));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      head       <= '0;
      tail       <= '0;
      slots_used <= '0;
      free_err   <= 1'b0;
    end else begin
      if (alloc)   head <= head + PTR_W'(1);
      if (free_ok) tail <= tail + PTR_W'(1);
      // Simultaneous alloc and free cancel out in the count while both pointers move.
      slots_used <= slots_used + CNT_W'(alloc) - CNT_W'(free_ok);
      if (free && (slots_used == '0)) free_err <= 1'b1;
    end
  end

  // Pointers wrap naturally; their distance must always equal the occupancy modulo the ring size.
  ring_distance_a : assert property (@(posedge clk) disable iff (!rstn)
    (PTR_W'(head - tail) == slots_used[PTR_W-1:0]));

endmodule

// File: rtl/pspin_ingress_slot_writer.sv
// Writes each matched packet into the next free fixed-size L2 slot and emits an (addr, len, trunc) descriptor.
// Latency: write beat one cycle after stream acceptance; descriptor valid the cycle after the final write is accepted.
// Backpressure: tready follows the single write register; tready=0 while the ring is full or a descriptor is pending.
//
// Ports: s_axis_* packet input; m_wr_* memory write port; m_desc_* descriptor output;
//        s_free_valid in-order slot release; free_err sticky underflow flag; slots_used occupancy.
module pspin_ingress_slot_writer
  import pspin_ingress_pkg::*;
#(
  parameter int unsigned         AXIS_IF_DATA_WIDTH = 512,
  parameter int unsigned         AXIS_IF_KEEP_WIDTH = AXIS_IF_DATA_WIDTH / 8,
  parameter int unsigned         ADDR_WIDTH         = 32,
  parameter logic [ADDR_WIDTH-1:0] BUF_BASE         = '0,
  parameter int unsigned         SLOT_BYTES         = 2048,
  parameter int unsigned         NUM_SLOTS          = 16,
  parameter int unsigned         LEN_WIDTH          = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [AXIS_IF_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [AXIS_IF_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic [ADDR_WIDTH-1:0]         m_wr_addr,
  output logic [AXIS_IF_DATA_WIDTH-1:0] m_wr_data,
  output logic [AXIS_IF_KEEP_WIDTH-1:0] m_wr_strb,
  output logic                          m_wr_valid,
  input  logic                          m_wr_ready,
  output logic [ADDR_WIDTH-1:0]         m_desc_addr,
  output logic [LEN_WIDTH-1:0]          m_desc_len,
  output logic                          m_desc_trunc,
  output logic                          m_desc_valid,
  input  logic                          m_desc_ready,
  input  logic                          s_free_valid,
  output logic                          free_err,
  output logic [$clog2(NUM_SLOTS):0]    slots_used
);

  localparam int unsigned BEATS      = slot_beats(SLOT_BYTES, AXIS_IF_KEEP_WIDTH);
  localparam int unsigned BEAT_CW    = $clog2(BEATS) + 1;
  localparam int unsigned PTR_W      = $clog2(NUM_SLOTS);
  localparam int unsigned SLOT_SHIFT = $clog2(SLOT_BYTES);
  localparam int unsigned BEAT_SHIFT = $clog2(AXIS_IF_KEEP_WIDTH);

  ingress_state_e         state_q, state_d;
  logic [PTR_W-1:0]       slot_q;
  logic [BEAT_CW-1:0]     beat_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic                   trunc_q;
  logic [PTR_W-1:0]       head;
  logic                   ring_full;
  logic                   commit;
  logic                   accept;
  logic                   slot_overflow;
  logic [ADDR_WIDTH-1:0]  slot_base;

  // BEATS is a power of two, so the counter's top bit is set exactly when the slot is full.
  assign slot_overflow = beat_q[BEAT_CW-1];
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign slot_base     = BUF_BASE + (ADDR_WIDTH'(slot_q) << SLOT_SHIFT);

  pspin_slot_ring #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_ring (
    .clk        (clk),
    .rstn       (rstn),
    .alloc      (commit),
    .free       (s_free_valid),
    .head       (head),
    .slots_used (slots_used),
    .full       (ring_full),
    .free_err   (free_err)
  );

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    s_axis_tready = 1'b0;
    commit        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!ring_full) state_d = ST_RECV;
      end
      ST_RECV: begin
        // Accept whenever the write register is empty or being drained this cycle.
        s_axis_tready = !m_wr_valid || m_wr_ready;
        if (s_axis_tvalid && (!m_wr_valid || m_wr_ready) && s_axis_tlast) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Publish only once the final write has left, so the descriptor never overtakes data.
        if ((!m_wr_valid || m_wr_ready) && (!m_desc_valid || m_desc_ready)) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      slot_q       <= '0;
      beat_q       <= '0;
      len_q        <= '0;
      trunc_q      <= 1'b0;
      m_wr_valid   <= 1'b0;
      m_desc_valid <= 1'b0;
    end else begin
      if (state_q == ST_IDLE) begin
        slot_q  <= head;
        beat_q  <= '0;
        len_q   <= '0;
        trunc_q <= 1'b0;
      end
      if (accept) begin
        if (!slot_overflow) begin
          beat_q <= beat_q + BEAT_CW'(1);
          len_q  <= len_q + LEN_WIDTH'($countones(s_axis_tkeep));
        end else begin
          trunc_q <= 1'b1;  // excess beats are swallowed; length stays at the slot size
        end
      end
      if (accept && !slot_overflow) m_wr_valid <= 1'b1;
      else if (m_wr_ready)          m_wr_valid <= 1'b0;
      if (commit)                   m_desc_valid <= 1'b1;
      else if (m_desc_ready)        m_desc_valid <= 1'b0;
    end
  end

  // Payload registers carry no reset; they are qualified by the valid flags above.
  always_ff @(posedge clk) begin
    if (accept && !slot_overflow) begin
      m_wr_addr <= slot_base + (ADDR_WIDTH'(beat_q) << BEAT_SHIFT);
      m_wr_data <= s_axis_tdata;
      m_wr_strb <= s_axis_tkeep;
    end
    if (commit) begin
      m_desc_addr  <= slot_base;
      m_desc_len   <= len_q;
      m_desc_trunc <= trunc_q;
    end
  end

endmodule

// File: tb/tb_pspin_ingress_slot_writer.sv
// Directed + randomized bench for pspin_ingress_slot_writer with a queue-based packet/slot reference model.
// Latency: n/a.
// Backpressure: m_wr_ready optionally randomized; m_desc_ready driven by the sequence.
module tb_pspin_ingress_slot_writer;

  localparam int KW     = 64;
  localparam int SB     = 2048;
  localparam int NS     = 16;
  localparam int SBEATS = SB / KW;
  localparam logic [31:0] BASE = 32'h0010_0000;

  logic         clk;
  logic         rstn;
  logic [511:0] s_axis_tdata;
  logic [63:0]  s_axis_tkeep;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [31:0]  m_wr_addr;
  logic [511:0] m_wr_data;
  logic [63:0]  m_wr_strb;
  logic         m_wr_valid;
  logic         m_wr_ready = 1'b1;
  logic [31:0]  m_desc_addr;
  logic [15:0]  m_desc_len;
  logic         m_desc_trunc;
  logic         m_desc_valid;
  logic         m_desc_ready;
  logic         s_free_valid;
  logic         free_err;
  logic [4:0]   slots_used;

  pspin_ingress_slot_writer #(
    .AXIS_IF_DATA_WIDTH (512),
    .AXIS_IF_KEEP_WIDTH (64),
    .ADDR_WIDTH         (32),
    .BUF_BASE           (BASE),
    .SLOT_BYTES         (SB),
    .NUM_SLOTS          (NS),
    .LEN_WIDTH          (16)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_wr_addr     (m_wr_addr),
    .m_wr_data     (m_wr_data),
    .m_wr_strb     (m_wr_strb),
    .m_wr_valid    (m_wr_valid),
    .m_wr_ready    (m_wr_ready),
    .m_desc_addr   (m_desc_addr),
    .m_desc_len    (m_desc_len),
    .m_desc_trunc  (m_desc_trunc),
    .m_desc_valid  (m_desc_valid),
    .m_desc_ready  (m_desc_ready),
    .s_free_valid  (s_free_valid),
    .free_err      (free_err),
    .slots_used    (slots_used)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [511:0] data; logic [63:0] strb; } wr_t;
  typedef struct { logic [31:0] addr; logic [15:0] len; logic trunc; } desc_t;

  wr_t   exp_wr[$], act_wr[$];
  desc_t exp_desc[$], act_desc[$];
  int    n_cmp = 0, n_err = 0;
  int    pkt_idx = 0, model_used = 0;
  bit    model_err = 1'b0;
  bit    wr_rand = 1'b0;

  // Observe handshakes mid-cycle, where valid/ready are stable until the next edge.
  always @(negedge clk) begin
    if (rstn) begin
      if (m_wr_valid && m_wr_ready)
        act_wr.push_back('{addr: m_wr_addr, data: m_wr_data, strb: m_wr_strb});
      if (m_desc_valid && m_desc_ready)
        act_desc.push_back('{addr: m_desc_addr, len: m_desc_len, trunc: m_desc_trunc});
    end
  end

  always begin
    @(posedge clk);
    #2;
    m_wr_ready = wr_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic logic [511:0] rand_data();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Reference model: slot k of the ring holds the k-th packet since reset; only the first
  // SBEATS beats are stored and counted, anything longer is flagged as truncated.
  task automatic send_pkt(input int beats, input int last_bytes, input bit gaps, input int abort_after);
    int           slot;
    int           len;
    int           nb;
    bit           acc;
    int           guard;
    logic [511:0] d;
    logic [63:0]  ones;
    logic [63:0]  k;
    slot = pkt_idx % NS;
    len  = 0;
    ones = '1;
    @(posedge clk);
    #2;
    for (int b = 0; b < beats; b++) begin
      if (abort_after >= 0 && b == abort_after) begin
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        return;
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_axis_tvalid = 1'b0;
        step(1);
      end
      nb = (b == beats - 1) ? last_bytes : KW;
      d  = rand_data();
      k  = ones >> (KW - nb);
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tlast  = (b == beats - 1);
      s_axis_tvalid = 1'b1;
      acc   = 1'b0;
      guard = 0;
      while (!acc && guard < 4000) begin
        @(negedge clk);
        acc = s_axis_tready;
        @(posedge clk);
        #2;
        guard++;
      end
      if (!acc) begin
        chk("send_accept_timeout", 512'(acc), 512'(1));
        s_axis_tvalid = 1'b0;
        return;
      end
      if (b < SBEATS) begin
        exp_wr.push_back('{addr: BASE + 32'(slot * SB + b * KW), data: d, strb: k});
        len += nb;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    exp_desc.push_back('{addr: BASE + 32'(slot * SB), len: 16'(len), trunc: (beats > SBEATS)});
    pkt_idx++;
    model_used++;
  endtask

  task automatic pulse_free();
    @(posedge clk);
    #2;
    s_free_valid = 1'b1;
    @(posedge clk);
    #2;
    s_free_valid = 1'b0;
    if (model_used > 0) model_used--;
    else                model_err = 1'b1;
  endtask

  task automatic wait_desc(input int n);
    int g;
    g = 0;
    while (act_desc.size() < n && g < 5000) begin
      step(1);
      g++;
    end
    chk("desc_arrived", 512'(act_desc.size() >= n), 512'(1));
  endtask

  task automatic check_all(input string tag);
    wr_t   a, e;
    desc_t ad, ed;
    chk({tag, ".wr_count"}, 512'(act_wr.size()), 512'(exp_wr.size()));
    while (exp_wr.size() > 0 && act_wr.size() > 0) begin
      a = act_wr.pop_front();
      e = exp_wr.pop_front();
      chk({tag, ".wr_addr"}, 512'(a.addr), 512'(e.addr));
      chk({tag, ".wr_strb"}, 512'(a.strb), 512'(e.strb));
      chk({tag, ".wr_data"}, a.data, e.data);
    end
    chk({tag, ".desc_count"}, 512'(act_desc.size()), 512'(exp_desc.size()));
    while (exp_desc.size() > 0 && act_desc.size() > 0) begin
      ad = act_desc.pop_front();
      ed = exp_desc.pop_front();
      chk({tag, ".desc_addr"}, 512'(ad.addr), 512'(ed.addr));
      chk({tag, ".desc_len"}, 512'(ad.len), 512'(ed.len));
      chk({tag, ".desc_trunc"}, 512'(ad.trunc), 512'(ed.trunc));
    end
    exp_wr.delete();
    act_wr.delete();
    exp_desc.delete();
    act_desc.delete();
  endtask

  task automatic clear_model();
    exp_wr.delete();
    act_wr.delete();
    exp_desc.delete();
    act_desc.delete();
    pkt_idx    = 0;
    model_used = 0;
    model_err  = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    chk({tag, ".tready"}, 512'(s_axis_tready), 512'(0));
    chk({tag, ".wr_valid"}, 512'(m_wr_valid), 512'(0));
    chk({tag, ".desc_valid"}, 512'(m_desc_valid), 512'(0));
    chk({tag, ".free_err"}, 512'(free_err), 512'(0));
    chk({tag, ".slots_used"}, 512'(slots_used), 512'(0));
  endtask

  initial begin
    rstn          = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_desc_ready  = 1'b1;
    s_free_valid  = 1'b0;
    step(3);
    check_reset_state("reset");
    @(posedge clk);
    #2;
    rstn = 1'b1;

    // 130-byte packet: three beats, two bytes on the last.
    send_pkt(3, 2, 1'b0, -1);
    wait_desc(1);
    check_all("pkt130");
    @(negedge clk);
    chk("pkt130.slots_used", 512'(slots_used), 512'(model_used));

    // Oversized 40-beat packet is truncated to the slot; the following packet uses the next slot.
    send_pkt(40, 64, 1'b0, -1);
    wait_desc(1);
    check_all("trunc40");
    send_pkt(2, 17, 1'b0, -1);
    wait_desc(1);
    check_all("after_trunc");

    // Fill the ring from slot 0, confirm back-pressure, then release one slot.
    @(posedge clk);
    #2;
    rstn = 1'b0;
    step(2);
    rstn = 1'b1;
    clear_model();
    for (int i = 0; i < NS; i++) send_pkt(1, int'($urandom_range(1, 64)), 1'b0, -1);
    wait_desc(NS);
    check_all("fill");
    step(5);
    @(negedge clk);
    chk("full.tready", 512'(s_axis_tready), 512'(0));
    chk("full.slots_used", 512'(slots_used), 512'(model_used));
    pulse_free();
    send_pkt(1, 40, 1'b0, -1);
    wait_desc(1);
    check_all("pkt17");
    @(negedge clk);
    chk("pkt17.slots_used", 512'(slots_used), 512'(model_used));

    // Drain the ring, then run two random packets under write and descriptor back-pressure.
    repeat (NS) pulse_free();
    @(negedge clk);
    chk("drained.slots_used", 512'(slots_used), 512'(model_used));
    @(posedge clk);
    #2;
    wr_rand      = 1'b1;
    m_desc_ready = 1'b0;
    send_pkt(int'($urandom_range(5, 20)), int'($urandom_range(1, 64)), 1'b1, -1);
    send_pkt(int'($urandom_range(5, 40)), int'($urandom_range(1, 64)), 1'b1, -1);
    step(10);
    @(negedge clk);
    chk("stall.desc_valid", 512'(m_desc_valid), 512'(1));
    chk("stall.desc_addr_held", 512'(m_desc_addr), 512'(exp_desc[0].addr));
    chk("stall.no_desc_taken", 512'(act_desc.size()), 512'(0));
    chk("stall.tready", 512'(s_axis_tready), 512'(0));
    @(posedge clk);
    #2;
    m_desc_ready = 1'b1;
    wait_desc(2);
    check_all("stall");
    wr_rand = 1'b0;

    // Bring occupancy to 4, then make a free coincide with the commit that would make it 6.
    send_pkt(1, 8, 1'b0, -1);
    send_pkt(2, 64, 1'b0, -1);
    wait_desc(2);
    check_all("pre_coinc");
    @(negedge clk);
    chk("pre_coinc.slots_used", 512'(slots_used), 512'(4));
    @(posedge clk);
    #2;
    m_desc_ready = 1'b0;
    send_pkt(2, 30, 1'b0, -1);
    step(3);
    send_pkt(3, 50, 1'b0, -1);
    step(4);
    @(negedge clk);
    chk("coinc.before", 512'(slots_used), 512'(model_used - 1));
    @(posedge clk);
    #2;
    m_desc_ready = 1'b1;
    s_free_valid = 1'b1;
    @(posedge clk);
    #2;
    s_free_valid = 1'b0;
    model_used--;
    @(negedge clk);
    chk("coinc.slots_used", 512'(slots_used), 512'(model_used));
    wait_desc(2);
    check_all("coinc");

    // Free everything, then one more free to trip the sticky underflow flag.
    repeat (5) pulse_free();
    @(negedge clk);
    chk("empty.slots_used", 512'(slots_used), 512'(model_used));
    chk("empty.free_err", 512'(free_err), 512'(model_err));
    pulse_free();
    @(negedge clk);
    chk("underflow.free_err", 512'(free_err), 512'(model_err));
    chk("underflow.slots_used", 512'(slots_used), 512'(model_used));

    // One-cycle reset in the middle of a 10-beat packet.
    send_pkt(10, 64, 1'b0, 4);
    rstn = 1'b0;
    step(1);
    rstn = 1'b1;
    check_reset_state("midreset");
    clear_model();
    send_pkt(2, 33, 1'b0, -1);
    wait_desc(1);
    check_all("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
